// File: rtl/imem_load_ctrl.sv
// Instruction-memory port arbiter: core fetch in RUN, byte-serial program load otherwise.
// Optional running word checksum of loaded data when IMEM_LOAD_CHECKSUM_EN is defined.
module imem_load_ctrl #(
  parameter int unsigned       ADDR_W   = 6,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_stall,
  output logic              core_rst_hold,
  input  logic              ld_start,
  input  logic              ld_done,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_byte,
  output logic              ld_overflow,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       ld_checksum
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);

  typedef enum logic [2:0] {RUN, LOAD, WRITE, DRAIN, RELEASE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q;
  logic [BCNT_W-1:0]   bcnt_q;
  logic [DATA_W-1:0]   word_q;
  logic                full_q;
  logic                ovf_q;
  logic                done_q;
  logic                acc_c;
  logic                last_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state and port muxing; fetch path is purely combinational in RUN
  always_comb begin
    state_d       = state_q;
    mem_addr      = wptr_q;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    fetch_data    = NOP_WORD;
    fetch_stall   = 1'b1;
    core_rst_hold = 1'b1;
    ld_ready      = 1'b0;
    acc_c         = 1'b0;
    last_c        = 1'b0;
    case (state_q)
      RUN: begin
        mem_addr      = fetch_addr;
        fetch_data    = mem_rdata;
        fetch_stall   = 1'b0;
        core_rst_hold = 1'b0;
        if (ld_start) state_d = LOAD;
      end
      LOAD: begin
        ld_ready = !full_q;
        acc_c    = ld_valid && !full_q;
        last_c   = acc_c && (bcnt_q == LAST_BYTE);
        // A byte arriving with done is counted before deciding whether to drain
        if (last_c)       state_d = WRITE;
        else if (ld_done) state_d = (acc_c || bcnt_q != '0) ? DRAIN : RELEASE;
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = word_q;
        state_d   = (done_q || ld_done) ? RELEASE : LOAD;
      end
      DRAIN: begin
        mem_we    = 1'b1;
        mem_wdata = word_q;
        state_d   = RELEASE;
      end
      RELEASE: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Word assembly, write pointer and session flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      bcnt_q <= '0;
      word_q <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (ld_start) begin
            wptr_q <= '0;
            bcnt_q <= '0;
            word_q <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
          end
        end
        LOAD: begin
          if (acc_c) begin
            word_q[{bcnt_q, 3'b000} +: 8] <= ld_byte;
            bcnt_q <= bcnt_q + BCNT_W'(1);
          end
          if (last_c && ld_done) done_q <= 1'b1;
          if (ld_valid && full_q) ovf_q <= 1'b1;
        end
        WRITE: begin
          word_q <= '0;
          bcnt_q <= '0;
          done_q <= 1'b0;
          // Saturate at the top word instead of wrapping onto address 0
          if (wptr_q == '1) full_q <= 1'b1;
          else              wptr_q <= wptr_q + ADDR_W'(1);
        end
        DRAIN: begin
          word_q <= '0;
          bcnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign ld_overflow = ovf_q;

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0] csum_q;

  // Modulo-2^32 sum of every word written during the session
  always_ff @(posedge clk) begin
    if (rst)                            csum_q <= '0;
    else if (state_q == RUN && ld_start) csum_q <= '0;
    else if (mem_we)                    csum_q <= csum_q + 32'(mem_wdata);
  end

  assign ld_checksum = csum_q;
`else
  assign ld_checksum = '0;
`endif

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: fetch vector tables plus a write scoreboard
// fed by a byte-stream model of the loader.
module tb_imem_load_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_stall;
  logic        core_rst_hold;
  logic        ld_start;
  logic        ld_done;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_byte;
  logic        ld_overflow;
  logic [5:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] ld_checksum;

  always #5 clk = ~clk;

  imem_load_ctrl dut (
    .clk(clk), .rst(rst),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data), .fetch_stall(fetch_stall),
    .core_rst_hold(core_rst_hold),
    .ld_start(ld_start), .ld_done(ld_done), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_byte(ld_byte), .ld_overflow(ld_overflow),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .ld_checksum(ld_checksum)
  );

  // Instruction memory model with asynchronous read
  logic [31:0] mem [64];
  logic        mem_init;

  function automatic logic [31:0] init_word(input int i);
    return (i == 5) ? 32'h0020_8233 : (32'hC000_005A | (32'(i) << 8));
  endfunction

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] exp;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_wr  = 0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  int          m_wptr;
  int          m_bcnt;
  logic [31:0] m_word;
  logic [31:0] m_sum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_ck();
`ifdef IMEM_LOAD_CHECKSUM_EN
    return m_sum;
`else
    return 32'h0;
`endif
  endfunction

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back('{addr: 6'(m_wptr), data: w});
    m_sum  = m_sum + w;
    m_wptr = m_wptr + 1;
  endtask

  // Scoreboard: every memory write must match the next word the model expects
  always @(negedge clk) begin
    #3;
    if (mem_we === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h, required no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
        chk("wr_data", mem_wdata, mon_e.data);
      end
    end
  end

  task automatic check_fetch(input logic [5:0] a, input logic [31:0] exp);
    @(negedge clk);
    fetch_addr = a;
    #1;
    chk("fetch_data", fetch_data, exp);
    chk("fetch_stall_run", 32'(fetch_stall), 32'd0);
  endtask

  task automatic start_session();
    @(negedge clk);
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    m_wptr = 0;
    m_bcnt = 0;
    m_word = '0;
    m_sum  = '0;
    #1;
    chk("start_hold", 32'(core_rst_hold), 32'd1);
    chk("start_stall", 32'(fetch_stall), 32'd1);
    chk("start_nop", fetch_data, NOP);
    chk("start_ready", 32'(ld_ready), 32'd1);
    chk("start_ovf", 32'(ld_overflow), 32'd0);
    chk("start_ck", ld_checksum, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic with_done);
    int n;
    n = 0;
    @(negedge clk);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_done  = with_done;
    #1;
    while (ld_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (ld_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got ld_ready %b after %0d cycles, required 1", ld_ready, n);
      ld_valid = 1'b0;
      ld_done  = 1'b0;
    end else begin
      chk("load_nop", fetch_data, NOP);
      @(posedge clk);
      m_word[8*m_bcnt +: 8] = b;
      m_bcnt++;
      if (m_bcnt == 4) begin
        push_word(m_word);
        m_word = '0;
        m_bcnt = 0;
      end
    end
  endtask

  task automatic finish_session();
    logic partial;
    partial = (m_bcnt != 0);
    if (partial) begin
      push_word(m_word);
      m_word = '0;
      m_bcnt = 0;
    end
    @(negedge clk);
    ld_valid = 1'b0;
    ld_done  = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
    #1;
    chk("done_hold_n1", 32'(core_rst_hold), 32'd1);
    if (partial) begin
      @(negedge clk);
      #1;
      chk("done_hold_n2", 32'(core_rst_hold), 32'd1);
    end
    @(negedge clk);
    #1;
    chk("run_hold", 32'(core_rst_hold), 32'd0);
    chk("run_stall", 32'(fetch_stall), 32'd0);
    chk("run_ready", 32'(ld_ready), 32'd0);
    chk("run_ck", ld_checksum, exp_ck());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 ns, required finish");
    $fatal(1);
  end

  initial begin
    vec_t vt_reset[4];
    vec_t vt_final[5];
    int   w0;

    vt_reset[0] = '{addr: 6'd5,  exp: 32'h0020_8233};
    vt_reset[1] = '{addr: 6'd0,  exp: 32'hC000_005A};
    vt_reset[2] = '{addr: 6'd63, exp: 32'hC000_3F5A};
    vt_reset[3] = '{addr: 6'd17, exp: 32'hC000_115A};
    vt_final[0] = '{addr: 6'd0,  exp: 32'h0000_0001};
    vt_final[1] = '{addr: 6'd1,  exp: 32'hFFFF_FFFF};
    vt_final[2] = '{addr: 6'd2,  exp: 32'h0000_0005};
    vt_final[3] = '{addr: 6'd3,  exp: 32'h0F0E_0D0C};
    vt_final[4] = '{addr: 6'd63, exp: 32'hFFFE_FDFC};

    rst = 1'b1; mem_init = 1'b1;
    ld_start = 1'b0; ld_done = 1'b0; ld_valid = 1'b0; ld_byte = '0;
    fetch_addr = 6'd5;
    m_wptr = 0; m_bcnt = 0; m_word = '0; m_sum = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hold", 32'(core_rst_hold), 32'd0);
    chk("rst_stall", 32'(fetch_stall), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_ovf", 32'(ld_overflow), 32'd0);
    chk("rst_ck", ld_checksum, 32'd0);
    mem_init = 1'b0;
    rst = 1'b0;

    foreach (vt_reset[i]) check_fetch(vt_reset[i].addr, vt_reset[i].exp);

    // One full word
    start_session();
    send_byte(8'h83, 1'b0); send_byte(8'h20, 1'b0);
    send_byte(8'h40, 1'b0); send_byte(8'h00, 1'b0);
    finish_session();
    check_fetch(6'd0, 32'h0040_2083);

    // Six bytes: one full word plus a drained partial word
    start_session();
    for (int k = 1; k <= 6; k++) send_byte(8'(k), 1'b0);
    finish_session();
    check_fetch(6'd0, 32'h0403_0201);
    check_fetch(6'd1, 32'h0000_0605);

    // Done coincident with the 4th byte: WRITE then RELEASE then RUN
    start_session();
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b1);
    @(negedge clk);
    ld_valid = 1'b0; ld_done = 1'b0;
    #1;
    chk("d4_write_hold", 32'(core_rst_hold), 32'd1);
    @(negedge clk); #1;
    chk("d4_release_hold", 32'(core_rst_hold), 32'd1);
    @(negedge clk); #1;
    chk("d4_run_hold", 32'(core_rst_hold), 32'd0);
    check_fetch(6'd0, 32'hDDCC_BBAA);

    // 260 bytes: memory fills at word 63, extra bytes overflow
    start_session();
    w0 = n_wr;
    for (int k = 0; k < 256; k++) send_byte(8'(k), 1'b0);
    @(negedge clk);
    ld_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_byte  = 8'(k);
      #1;
      chk("full_ready", 32'(ld_ready), 32'd0);
    end
    @(negedge clk);
    ld_valid = 1'b0;
    #1;
    chk("full_ovf", 32'(ld_overflow), 32'd1);
    finish_session();
    chk("full_writes", 32'(n_wr - w0), 32'd64);

    // Checksum words 1, FFFFFFFF, 5
    start_session();
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    @(negedge clk); ld_valid = 1'b0;
    @(negedge clk); #1;
    chk("ck_w1", ld_checksum, exp_ck());
    for (int k = 0; k < 4; k++) send_byte(8'hFF, 1'b0);
    @(negedge clk); ld_valid = 1'b0;
    @(negedge clk); #1;
    chk("ck_w2", ld_checksum, exp_ck());
    send_byte(8'h05, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    finish_session();

    // Reset two bytes into a word: session abandoned, nothing written
    start_session();
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    @(negedge clk);
    ld_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_hold", 32'(core_rst_hold), 32'd0);
    chk("mid_rst_stall", 32'(fetch_stall), 32'd0);
    chk("mid_rst_ready", 32'(ld_ready), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_wdata", mem_wdata, 32'd0);
    chk("mid_rst_ck", ld_checksum, 32'd0);
    rst = 1'b0;
    m_bcnt = 0;
    m_word = '0;

    foreach (vt_final[i]) check_fetch(vt_final[i].addr, vt_final[i].exp);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Sequencer and port arbiter for the 64 x 32-bit instruction memory. Shares the single memory port between the core fetch path and a byte-serial program loader. Assembles loader bytes into little-endian words and writes them from address 0 upward. Stalls fetch and holds the core in reset for the whole load session.

## Interface
- ADDR_W, 6, word-address width (memory depth 2^ADDR_W)
- DATA_W, 32, instruction width
- NOP_WORD, 32'h0000_0013, value returned on fetch_data while fetch is blocked
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_addr  in  ADDR_W  core word address (PC[7:2])
- fetch_data  out  DATA_W  instruction to core
- fetch_stall  out  1  core must not advance PC
- core_rst_hold  out  1  holds core in reset
- ld_start  in  1  begin load session (pulse)
- ld_done  in  1  end load session (pulse)
- ld_valid  in  1  ld_byte valid
- ld_ready  out  1  controller accepts byte
- ld_byte  in  8  program byte
- ld_overflow  out  1  sticky: session exceeded memory depth
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data (asynchronous read)
- ld_checksum  out  32  running word sum (see Configuration)

## Operation
- States:
  - RUN: mem_addr = fetch_addr, fetch_data = mem_rdata (combinational), fetch_stall = 0, core_rst_hold = 0, ld_ready = 0.
  - LOAD: fetch_stall = 1, core_rst_hold = 1, fetch_data = NOP_WORD, mem_addr = wptr.
  - WRITE: one cycle; mem_we = 1, mem_wdata = assembled word, mem_addr = wptr, ld_ready = 0.
  - DRAIN: one cycle; writes the zero-padded partial word at wptr.
  - RELEASE: one cycle; core_rst_hold = 1, fetch_stall = 1.
- Transitions:
  - RUN -> LOAD on ld_start. Clears wptr, bcnt, ld_overflow and checksum. ld_start is ignored in every other state.
  - LOAD: ld_ready = !full. A byte is accepted when ld_valid && ld_ready. It goes to word bits [8*bcnt+7 : 8*bcnt], and bcnt increments.
  - LOAD -> WRITE when the 4th byte is accepted. WRITE -> LOAD; wptr++ and bcnt = 0.
  - When WRITE targets address 2^ADDR_W-1, full is set instead of wrapping. ld_ready stays 0 for the rest of the session.
  - ld_valid while full: set ld_overflow. The byte is not accepted.
  - ld_done in LOAD: go to DRAIN if bcnt != 0, else go to RELEASE. DRAIN -> RELEASE. RELEASE -> RUN.
  - ld_done in the same cycle as an accepted byte: the byte is counted first, then the done transition uses the updated bcnt.
  - ld_done in the same cycle as the 4th byte: go to WRITE; the done is latched and the controller exits WRITE to RELEASE.
  - ld_done in WRITE: latched; the controller exits WRITE to RELEASE (bcnt is 0 after the write).
  - ld_done in DRAIN or RELEASE: ignored.
- Byte packing: the first byte of each word lands in [7:0] (little-endian).

## Timing
- Fetch read in RUN has zero latency (pure combinational path through the memory).
- A 4th byte accepted in cycle N produces mem_we = 1 in cycle N+1. The next byte is accepted no earlier than N+2.
- Sustained load rate: 4 bytes per 5 cycles.
- ld_done in cycle N returns to RUN at cycle N+2 (no partial word) or N+3 (partial word).
- Reset values: state RUN; wptr 0; bcnt 0; full 0; mem_we 0; ld_ready 0; fetch_stall 0; core_rst_hold 0; ld_overflow 0; ld_checksum 0; mem_wdata 0.
- Reset mid-session: the session is abandoned and the controller returns to RUN. Words already written stay in memory.

## Configuration
- IMEM_LOAD_CHECKSUM_EN defined:
  - ld_checksum accumulates the modulo-2^32 sum of every word written (WRITE and DRAIN).
  - It is cleared on ld_start and held stable in RUN.
- Undefined: ld_checksum is tied to 0 and no accumulator is synthesized.

## Test plan
- Reset then RUN: fetch_addr = 5 with mem[5] = 0x00208233 -> fetch_data = 0x00208233, fetch_stall = 0, ld_ready = 0.
- ld_start, bytes 0x83,0x20,0x40,0x00 -> one mem_we at addr 0 with wdata 0x00402083. fetch_data = 0x00000013 throughout; core_rst_hold = 1.
- 6 bytes 01..06 then ld_done -> writes 0x04030201 at addr 0 and 0x00000605 at addr 1 (DRAIN). RELEASE for 1 cycle, then RUN.
- 260 bytes streamed:
  - exactly 64 words written (addr 0..63, no wrap); ld_ready = 0 after addr 63;
  - ld_overflow = 1; after ld_done, back to RUN.
- Reset asserted after 2 bytes of a word -> next cycle RUN, no mem_we, all outputs at reset values.
- With IMEM_LOAD_CHECKSUM_EN, words 0x00000001 and 0xFFFFFFFF loaded -> ld_checksum = 0x00000000; a third word 0x00000005 -> 0x00000005.
